eth_hdr_rx_filter: RTL and testbench

//  Byte-stream Ethernet header parser with destination-MAC filtering, directly after the MII RX AXI-stream.

---
 rtl/eth_rx_pkg.sv | 14 +
 rtl/eth_mac_filter.sv | 30 +++
 rtl/eth_hdr_rx_filter.sv | 153 +++++++++++++++
 tb/tb_eth_hdr_rx_filter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared types and constants for the Ethernet RX header filter.
// ETH_RX_VLAN_EN (defined in the design files) enables 802.1Q tag parsing.
package eth_rx_pkg;
    typedef logic [47:0] mac_addr_t;
    localparam int ETH_HDR_BYTES = 14;
    localparam int ETH_VLAN_HDR_BYTES = 18;
    localparam logic [15:0] ETH_TPID_VLAN = 16'h8100;
    localparam mac_addr_t ETH_MAC_BCAST = 48'hFFFF_FFFF_FFFF;
    typedef enum logic [2:0] {S_HDR, S_DECIDE, S_HDR_OUT, S_PAYLOAD, S_DROP} rx_state_t;
    // group bit is the LSB of the first byte on the wire
    function automatic logic is_mcast(input mac_addr_t a);
        return a[40] && (a != ETH_MAC_BCAST);
    endfunction
endpackage

// File: rtl/eth_mac_filter.sv
// eth_mac_filter: destination MAC table compare with lowest-index priority plus mode acceptance.
module eth_mac_filter import eth_rx_pkg::*; #(
    parameter int NUM_MAC_FILTERS = 4,
    localparam int HW = $clog2(NUM_MAC_FILTERS) + 1
) (
    input  mac_addr_t                      i_dest,
    input  logic [48*NUM_MAC_FILTERS-1:0] i_mac_addr,
    input  logic [NUM_MAC_FILTERS-1:0]    i_mac_valid,
    input  logic                           i_promisc,
    input  logic                           i_accept_bcast,
    input  logic                           i_accept_mcast,
    output logic                           o_accept,
    output logic [HW-1:0]                  o_hit
);
    logic          w_tbl;
    logic [HW-1:0] w_idx;
    // scanning downwards leaves the lowest matching entry in w_idx
    always_comb begin
        w_tbl = 1'b0;
        w_idx = HW'(NUM_MAC_FILTERS);
        for (int i = NUM_MAC_FILTERS - 1; i >= 0; i--)
            if (i_mac_valid[i] && i_dest == i_mac_addr[48*i +: 48]) begin
                w_tbl = 1'b1;
                w_idx = HW'(i);
            end
    end
    assign o_accept = w_tbl | i_promisc | ((i_dest == ETH_MAC_BCAST) & i_accept_bcast)
                    | (is_mcast(i_dest) & i_accept_mcast);
    assign o_hit = w_idx;
endmodule

// File: rtl/eth_hdr_rx_filter.sv
// eth_hdr_rx_filter: byte-stream Ethernet header parser with destination MAC filtering.
// Define ETH_RX_VLAN_EN to parse an 802.1Q tag (18-byte header when TPID 8100 is seen).
module eth_hdr_rx_filter import eth_rx_pkg::*; #(
    parameter int NUM_MAC_FILTERS = 4,
    parameter int DROP_CNT_WIDTH = 16,
    localparam int HW = $clog2(NUM_MAC_FILTERS) + 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [7:0]                     s_axis_tdata,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tlast,
    input  logic                           s_axis_tuser,
    output logic                           s_axis_tready,
    input  logic [48*NUM_MAC_FILTERS-1:0] cfg_mac_addr,
    input  logic [NUM_MAC_FILTERS-1:0]    cfg_mac_valid,
    input  logic                           cfg_promisc,
    input  logic                           cfg_accept_bcast,
    input  logic                           cfg_accept_mcast,
    output logic                           m_hdr_valid,
    input  logic                           m_hdr_ready,
    output logic [47:0]                    m_dest_mac,
    output logic [47:0]                    m_src_mac,
    output logic [15:0]                    m_eth_type,
    output logic                           m_vlan_valid,
    output logic [15:0]                    m_vlan_tci,
    output logic [HW-1:0]                  m_filter_hit,
    output logic [7:0]                     m_axis_tdata,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tuser,
    input  logic                           m_axis_tready,
    output logic                           busy,
    output logic                           error_header_early_termination,
    output logic                           frame_dropped,
    output logic [DROP_CNT_WIDTH-1:0]      drop_count
);
    rx_state_t                 r_state, w_state_nxt;
    logic [4:0]                r_cnt;
    mac_addr_t                 r_dest, r_src;
    logic [15:0]               r_type;
    logic [HW-1:0]             r_hit;
    logic [7:0]                r_tdata;
    logic                      r_tvalid, r_tlast, r_tuser, r_err, r_drop;
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;
    logic                      w_beat, w_hdr_beat, w_hdr_end, w_drop_done, w_accept;
    logic [HW-1:0]             w_hit;
    logic [15:0]               w_type_nxt;

    assign s_axis_tready = (r_state == S_HDR) | (r_state == S_DROP)
                         | ((r_state == S_PAYLOAD) & (!r_tvalid | m_axis_tready));
    assign w_beat      = s_axis_tvalid & s_axis_tready;
    assign w_hdr_beat  = w_beat & (r_state == S_HDR);
    assign w_drop_done = w_beat & s_axis_tlast & (r_state == S_DROP);
    assign w_type_nxt  = {r_type[7:0], s_axis_tdata};

`ifdef ETH_RX_VLAN_EN
    logic        r_vlan;
    logic [15:0] r_tci;
    assign w_hdr_end = (r_cnt == 5'(ETH_VLAN_HDR_BYTES - 1))
                     || (r_cnt == 5'(ETH_HDR_BYTES - 1) && w_type_nxt != ETH_TPID_VLAN);
    assign m_vlan_valid = r_vlan;
    assign m_vlan_tci   = r_tci;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_vlan <= 1'b0;
            r_tci  <= '0;
        end else if (w_hdr_beat && r_cnt == 5'd13) begin
            r_vlan <= w_type_nxt == ETH_TPID_VLAN;
            r_tci  <= '0;
        end else if (w_hdr_beat && (r_cnt == 5'd14 || r_cnt == 5'd15))
            r_tci <= {r_tci[7:0], s_axis_tdata};
`else
    assign w_hdr_end    = r_cnt == 5'(ETH_HDR_BYTES - 1);
    assign m_vlan_valid = 1'b0;
    assign m_vlan_tci   = '0;
`endif

    eth_mac_filter #(.NUM_MAC_FILTERS(NUM_MAC_FILTERS)) u_filter (
        .i_dest         (r_dest),
        .i_mac_addr     (cfg_mac_addr),
        .i_mac_valid    (cfg_mac_valid),
        .i_promisc      (cfg_promisc),
        .i_accept_bcast (cfg_accept_bcast),
        .i_accept_mcast (cfg_accept_mcast),
        .o_accept       (w_accept),
        .o_hit          (w_hit)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_state <= S_HDR;
        else          r_state <= w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HDR:     if (w_hdr_beat && !s_axis_tlast && w_hdr_end) w_state_nxt = S_DECIDE;
            S_DECIDE:  w_state_nxt = w_accept ? S_HDR_OUT : S_DROP;
            S_HDR_OUT: if (m_hdr_ready) w_state_nxt = S_PAYLOAD;
            S_PAYLOAD: if (w_beat && s_axis_tlast) w_state_nxt = S_HDR;
            S_DROP:    if (w_drop_done) w_state_nxt = S_HDR;
            default:   w_state_nxt = S_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_cnt      <= '0;
            r_dest     <= '0;
            r_src      <= '0;
            r_type     <= '0;
            r_hit      <= '0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_tuser    <= 1'b0;
            r_err      <= 1'b0;
            r_drop     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_err  <= w_hdr_beat & s_axis_tlast;
            r_drop <= w_drop_done;
            if (w_drop_done && !(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + 1'b1;
            if (w_hdr_beat) begin
                r_cnt <= (s_axis_tlast || w_hdr_end) ? 5'd0 : r_cnt + 5'd1;
                // bytes 14-15 are the VLAN TCI, handled with the tag registers
                if (r_cnt < 5'd6) r_dest <= {r_dest[39:0], s_axis_tdata};
                else if (r_cnt < 5'd12) r_src <= {r_src[39:0], s_axis_tdata};
                else if (r_cnt < 5'd14 || r_cnt > 5'd15) r_type <= w_type_nxt;
            end
            if (r_state == S_DECIDE) r_hit <= w_hit;
            if (r_state == S_PAYLOAD && w_beat) begin
                r_tvalid <= 1'b1;
                r_tdata  <= s_axis_tdata;
                r_tlast  <= s_axis_tlast;
                r_tuser  <= s_axis_tuser;
            end else if (m_axis_tready) r_tvalid <= 1'b0;
        end

    assign m_hdr_valid   = r_state == S_HDR_OUT;
    assign m_dest_mac    = r_dest;
    assign m_src_mac     = r_src;
    assign m_eth_type    = r_type;
    assign m_filter_hit  = r_hit;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tuser  = r_tuser;
    assign busy          = (r_state != S_HDR) || (r_cnt != 5'd0);
    assign error_header_early_termination = r_err;
    assign frame_dropped = r_drop;
    assign drop_count    = r_drop_cnt;
endmodule

// File: tb/tb_eth_hdr_rx_filter.sv
// tb_eth_hdr_rx_filter: directed self-checking bench for eth_hdr_rx_filter (default 4 filters).
// Expectations for the tag test follow ETH_RX_VLAN_EN when it is defined.
module tb_eth_hdr_rx_filter;
    typedef struct {
        logic [47:0] d, s;
        logic [15:0] t, tci;
        logic        v;
        logic [2:0]  hit;
        int          cyc;
    } hdr_t;

    localparam logic [47:0] MAC0 = 48'h02_00_00_00_00_10;
    localparam logic [47:0] MAC1 = 48'h02_00_00_00_00_11;
    localparam logic [47:0] MAC2 = 48'h02_00_00_00_00_12;
    localparam logic [47:0] MAC3 = 48'h02_00_00_00_00_13;
    localparam logic [47:0] SRC  = 48'h0a_0b_0c_0d_0e_0f;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0, s_axis_tready;
    logic [191:0] cfg_mac_addr;
    logic [3:0]  cfg_mac_valid = 4'b1111;
    logic        cfg_promisc = 1'b0, cfg_accept_bcast = 1'b0, cfg_accept_mcast = 1'b0;
    logic        m_hdr_valid, m_hdr_ready;
    logic [47:0] m_dest_mac, m_src_mac;
    logic [15:0] m_eth_type, m_vlan_tci;
    logic        m_vlan_valid;
    logic [2:0]  m_filter_hit;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
    logic        busy, error_header_early_termination, frame_dropped;
    logic [15:0] drop_count;

    logic rnd = 1'b0, hr_rnd = 1'b1, tr_rnd = 1'b1, tr_fix = 1'b1;
    assign m_hdr_ready   = rnd ? hr_rnd : 1'b1;
    assign m_axis_tready = rnd ? tr_rnd : tr_fix;
    assign cfg_mac_addr  = {MAC3, MAC2, MAC1, MAC0};

    int checks = 0, failures = 0, cyc = 0, n_err = 0, n_drop = 0, t13 = 0, hv_rise = 0;
    logic hv_prev = 1'b0;
    hdr_t hq[$];
    logic [9:0] pq[$], eq[$];
    logic [7:0] fq[$];

    eth_hdr_rx_filter #(.NUM_MAC_FILTERS(4), .DROP_CNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
        .cfg_mac_addr(cfg_mac_addr), .cfg_mac_valid(cfg_mac_valid), .cfg_promisc(cfg_promisc),
        .cfg_accept_bcast(cfg_accept_bcast), .cfg_accept_mcast(cfg_accept_mcast),
        .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready), .m_dest_mac(m_dest_mac),
        .m_src_mac(m_src_mac), .m_eth_type(m_eth_type), .m_vlan_valid(m_vlan_valid),
        .m_vlan_tci(m_vlan_tci), .m_filter_hit(m_filter_hit),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
        .busy(busy), .error_header_early_termination(error_header_early_termination),
        .frame_dropped(frame_dropped), .drop_count(drop_count)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    // random downstream stalls, changed just after each rising edge
    initial forever begin
        @(posedge clk);
        #1;
        hr_rnd = 1'($urandom_range(0, 1));
        tr_rnd = 1'($urandom_range(0, 1));
    end
    // observe handshakes and pulses on the falling edge
    initial forever begin
        @(negedge clk);
        if (m_hdr_valid && !hv_prev) hv_rise = cyc;
        hv_prev = m_hdr_valid;
        if (m_hdr_valid && m_hdr_ready)
            hq.push_back('{m_dest_mac, m_src_mac, m_eth_type, m_vlan_tci, m_vlan_valid, m_filter_hit, hv_rise});
        if (m_axis_tvalid && m_axis_tready) pq.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
        if (error_header_early_termination) n_err++;
        if (frame_dropped) n_drop++;
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, o, e);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input logic u, output int a);
        int n = 0;
        s_axis_tdata = d;
        s_axis_tlast = l;
        s_axis_tuser = u;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!s_axis_tready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!s_axis_tready) chk("tready_timeout", s_axis_tready, 1);
        a = cyc;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        s_axis_tuser = 1'b0;
    endtask

    task automatic send_q(input logic l, input logic u);
        int a;
        for (int i = 0; i < fq.size(); i++) begin
            send_byte(fq[i], l && i == fq.size() - 1, u && l && i == fq.size() - 1, a);
            if (i == 13) t13 = a;
        end
        fq.delete();
    endtask

    task automatic hdr(input logic [47:0] d, input logic [15:0] t);
        for (int i = 0; i < 6; i++) fq.push_back(d[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fq.push_back(SRC[47-8*i -: 8]);
        fq.push_back(t[15:8]);
        fq.push_back(t[7:0]);
    endtask

    task automatic frame(input logic [47:0] d, input logic [15:0] t, input int n, input logic [7:0] b,
                         input logic u, input logic pass);
        hdr(d, t);
        for (int i = 0; i < n; i++) begin
            fq.push_back(b + 8'(i));
            if (pass) eq.push_back({u && i == n - 1, i == n - 1, b + 8'(i)});
        end
        send_q(1'b1, u);
    endtask

    task automatic wait_pl(input int pb);
        for (int i = 0; i < 3000 && pq.size() < pb + eq.size(); i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic chk_pl(input int pb);
        chk("pl_len", pq.size() - pb, eq.size());
        for (int i = 0; i < eq.size() && pb + i < pq.size(); i++) chk("pl_beat", pq[pb+i], eq[i]);
    endtask

    task automatic chk_hdr(input int k, input logic [2:0] hit, input logic [47:0] d, input logic [15:0] t);
        if (hq.size() > k) begin
            chk("hdr_hit", hq[k].hit, hit);
            chk("hdr_dest", hq[k].d, d);
            chk("hdr_src", hq[k].s, SRC);
            chk("hdr_type", hq[k].t, t);
        end
    endtask

    task automatic accept_one(input logic [47:0] d, input logic [15:0] t, input int n, input logic [7:0] b,
                              input logic [2:0] hit);
        int hb = hq.size(), pb = pq.size();
        eq.delete();
        frame(d, t, n, b, 1'b0, 1'b1);
        wait_pl(pb);
        chk("hdr_cnt", hq.size() - hb, 1);
        chk_hdr(hb, hit, d, t);
        chk_pl(pb);
    endtask

    task automatic drop_one(input logic [47:0] d, input logic [15:0] exp_cnt);
        int hb = hq.size(), pb = pq.size(), nd = n_drop;
        frame(d, 16'h0800, 5, 8'h50, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("drop_pulse", n_drop - nd, 1);
        chk("drop_count", drop_count, exp_cnt);
        chk("drop_no_hdr", hq.size() - hb, 0);
        chk("drop_no_pl", pq.size() - pb, 0);
    endtask

    initial begin
        int hb, pb, ne;
        #3;
        chk("rst_tready", s_axis_tready, 1);
        chk("rst_hdr_valid", m_hdr_valid, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_pulses", {frame_dropped, error_header_early_termination}, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // table hit on entry 2, latency from last header byte
        hb = hq.size();
        accept_one(MAC2, 16'h0800, 20, 8'h30, 3'd2);
        if (hq.size() > hb) chk("hdr_latency", hq[hb].cyc, t13 + 2);
        chk("busy_idle", busy, 0);

        // unmatched unicast is dropped
        drop_one(48'h02_00_00_00_00_99, 16'd1);

        // broadcast modes
        cfg_accept_bcast = 1'b1;
        accept_one(48'hFFFF_FFFF_FFFF, 16'h0806, 3, 8'h40, 3'd4);
        cfg_accept_bcast = 1'b0;
        drop_one(48'hFFFF_FFFF_FFFF, 16'd2);

        // multicast, promiscuous and table priority over mode accept
        cfg_accept_mcast = 1'b1;
        accept_one(48'h01_00_5e_00_00_01, 16'h0800, 2, 8'h48, 3'd4);
        cfg_accept_mcast = 1'b0;
        cfg_promisc = 1'b1;
        accept_one(MAC1, 16'h0800, 2, 8'h4c, 3'd1);
        accept_one(48'h02_00_00_00_00_77, 16'h0800, 2, 8'h4e, 3'd4);
        cfg_promisc = 1'b0;
        cfg_mac_valid = 4'b1011;
        drop_one(MAC2, 16'd3);
        cfg_mac_valid = 4'b1111;

        // early termination on byte 9 and on byte 13
        hb = hq.size();
        ne = n_err;
        hdr(MAC0, 16'h0800);
        fq = fq[0:9];
        send_q(1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("err_b9_pulse", n_err - ne, 1);
        hdr(MAC0, 16'h0800);
        send_q(1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("err_b13_pulse", n_err - ne, 2);
        chk("err_no_hdr", hq.size() - hb, 0);
        accept_one(MAC0, 16'h0800, 6, 8'h70, 3'd0);

        // three back-to-back frames under random stalls
        hb = hq.size();
        pb = pq.size();
        eq.delete();
        rnd = 1'b1;
        frame(MAC1, 16'h88b5, 7, 8'h80, 1'b0, 1'b1);
        frame(MAC3, 16'h0806, 1, 8'h90, 1'b1, 1'b1);
        frame(MAC0, 16'h86dd, 12, 8'ha0, 1'b0, 1'b1);
        wait_pl(pb);
        rnd = 1'b0;
        chk("b2b_hdr_cnt", hq.size() - hb, 3);
        chk_hdr(hb, 3'd1, MAC1, 16'h88b5);
        chk_hdr(hb + 1, 3'd3, MAC3, 16'h0806);
        chk_hdr(hb + 2, 3'd0, MAC0, 16'h86dd);
        chk_pl(pb);

        // 802.1Q tagged frame
        hb = hq.size();
        pb = pq.size();
        eq.delete();
        hdr(MAC2, 16'h8100);
        fq.push_back(8'h60);
        fq.push_back(8'h05);
        fq.push_back(8'h08);
        fq.push_back(8'h00);
`ifndef ETH_RX_VLAN_EN
        eq.push_back(10'h060);
        eq.push_back(10'h005);
        eq.push_back(10'h008);
        eq.push_back(10'h000);
`endif
        for (int i = 0; i < 4; i++) begin
            fq.push_back(8'hc0 + 8'(i));
            eq.push_back({1'b0, i == 3, 8'hc0 + 8'(i)});
        end
        send_q(1'b1, 1'b0);
        wait_pl(pb);
        chk("vlan_hdr_cnt", hq.size() - hb, 1);
        if (hq.size() > hb) begin
`ifdef ETH_RX_VLAN_EN
            chk("vlan_type", hq[hb].t, 16'h0800);
            chk("vlan_valid", hq[hb].v, 1);
            chk("vlan_tci", hq[hb].tci, 16'h6005);
`else
            chk("vlan_type", hq[hb].t, 16'h8100);
            chk("vlan_valid", hq[hb].v, 0);
            chk("vlan_tci", hq[hb].tci, 16'h0000);
`endif
        end
        chk_pl(pb);

        // reset while a payload beat is held in the output stage
        hb = hq.size();
        pb = pq.size();
        tr_fix = 1'b0;
        hdr(MAC2, 16'h0800);
        fq.push_back(8'he0);
        send_q(1'b0, 1'b0);
        chk("mid_tvalid", m_axis_tvalid, 1);
        chk("mid_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_tvalid", m_axis_tvalid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_hdr_valid", m_hdr_valid, 0);
        chk("arst_tready", s_axis_tready, 1);
        chk("arst_drop_count", drop_count, 0);
        chk("arst_fields", {m_filter_hit, m_dest_mac}, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tr_fix = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_no_pl", pq.size() - pb, 0);
        accept_one(MAC3, 16'h0800, 5, 8'hf0, 3'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
